// File: rtl/router_pkg.sv
// router_pkg: flit-type encodings, default widths and the type-field locator
// shared by the router input-port slice.
package router_pkg;
  localparam int DEF_DATA_W = 35;
  localparam int DEF_NUM_VC = 2;
  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;
  function automatic int ft_lsb(input int data_w);
    return data_w - 2;
  endfunction
endpackage

// File: rtl/router_vc_fifo.sv
// router_vc_fifo: single-VC synchronous FIFO; the owner never pushes when full
// nor pops when empty, so no internal guarding is needed.
module router_vc_fifo #(
  parameter int DATA_W = 35,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  assign dout = mem[rd];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= wr + AW'(push);
      rd <= rd + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/router_vc_inport.sv
// router_vc_inport: per-VC flit buffering with round-robin drain onto one registered link.
// Define ROUTER_VCINPORT_DROPCNT_EN to add the saturating DROPCNT rejected-flit counter.
module router_vc_inport
  import router_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_VC = DEF_NUM_VC,
  parameter int DEPTH = 4,
  localparam int VCH_W = $clog2(NUM_VC)
) (
  input  logic              clk,
  input  logic              RST_,
  input  logic [DATA_W-1:0] IDATA,
  input  logic              IVALID,
  input  logic [VCH_W-1:0]  IVCH,
  output logic [NUM_VC-1:0] OACK,
  output logic [NUM_VC-1:0] ORDY,
  output logic [NUM_VC-1:0] OLCK,
  output logic [DATA_W-1:0] ODATA,
  output logic              OVALID,
  output logic [VCH_W-1:0]  OVCH,
  input  logic [NUM_VC-1:0] IRDY
`ifdef ROUTER_VCINPORT_DROPCNT_EN
  ,
  output logic [15:0]       DROPCNT
`endif
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int FT = ft_lsb(DATA_W);
  logic [NUM_VC-1:0] push, pop, full, empty, elig, head_set, tail_clr;
  logic [NUM_VC-1:0][DATA_W-1:0] dout;
  logic [NUM_VC-1:0][CNT_W-1:0] cnt;
  logic [VCH_W-1:0] rr, gnt, idx;
  logic gnt_v, in_ok;
  assign in_ok = IVALID && ({1'b0, IVCH} < (VCH_W+1)'(NUM_VC)) && (cnt[IVCH] < CNT_W'(DEPTH));
  assign push = in_ok ? NUM_VC'(1) << IVCH : '0;
  assign pop = gnt_v ? NUM_VC'(1) << gnt : '0;
  assign elig = ~empty & IRDY;
  assign ORDY = ~full;
  assign head_set = IDATA[FT +: 2] == FT_HEAD ? push : '0;
  assign tail_clr = dout[gnt][FT +: 2] == FT_TAIL ? pop : '0;
  // Walk downward so the VC nearest rr+1 is the last (winning) assignment.
  always_comb begin
    gnt_v = 1'b0;
    gnt = '0;
    idx = '0;
    for (int i = NUM_VC; i >= 1; i--) begin
      idx = VCH_W'((int'(rr) + i) % NUM_VC);
      if (elig[idx]) begin
        gnt_v = 1'b1;
        gnt = idx;
      end
    end
  end
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    router_vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst_n(RST_), .push(push[v]), .pop(pop[v]), .din(IDATA),
      .dout(dout[v]), .full(full[v]), .empty(empty[v]), .count(cnt[v])
    );
  end
  always_ff @(posedge clk or negedge RST_)
    if (!RST_) begin
      OACK <= '0;
      OLCK <= '0;
      ODATA <= '0;
      OVALID <= 1'b0;
      OVCH <= '0;
      rr <= VCH_W'(NUM_VC - 1);
    end else begin
      OACK <= push;
      OVALID <= gnt_v;
      OLCK <= (OLCK & ~tail_clr) | head_set;
      if (gnt_v) begin
        ODATA <= dout[gnt];
        OVCH <= gnt;
        rr <= gnt;
      end
    end
`ifdef ROUTER_VCINPORT_DROPCNT_EN
  always_ff @(posedge clk or negedge RST_)
    if (!RST_) DROPCNT <= '0;
    else if (IVALID && !in_ok && DROPCNT != 16'hFFFF) DROPCNT <= DROPCNT + 16'd1;
`endif
endmodule
